// File: rtl/int2float_pipe.sv
// int2float_pipe: two-stage unsigned integer to mini-float converter with valid/ready
// flow control and exponent saturation.
// Build option: define INT2FLOAT_RNE_EN to round the discarded bits to nearest, ties to even;
// without it the mantissa is truncated (round toward zero).
module int2float_pipe #(
  parameter int unsigned IN_W  = 11,
  parameter int unsigned EXP_W = 3,
  parameter int unsigned MAN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_man,
  output logic             out_sat
);

  localparam int unsigned P_W     = $clog2(IN_W);
  localparam logic [31:0] EXP_MAX = 32'((1 << EXP_W) - 1);

  // Stage 1 state: captured word, leading-one index and small-value flag
  logic             r_s1_valid;
  logic [IN_W-1:0]  r_s1_x;
  logic [P_W-1:0]   r_s1_p;
  logic             r_s1_small;

  // Stage 2 state drives the outputs directly
  logic             r_s2_valid;
  logic [EXP_W-1:0] r_exp;
  logic [MAN_W-1:0] r_man;
  logic             r_sat;

  logic             w_s1_adv;
  logic             w_s2_adv;
  logic [P_W-1:0]   w_p;
  logic             w_small;
  logic [P_W-1:0]   w_shamt;
  logic [MAN_W-1:0] w_man_t;
  logic [31:0]      w_exp_t;
  logic [MAN_W-1:0] w_man_r;
  logic [31:0]      w_exp_r;
  logic [EXP_W-1:0] w_exp_n;
  logic [MAN_W-1:0] w_man_n;
  logic             w_sat_n;

`ifdef INT2FLOAT_RNE_EN
  localparam int unsigned MAN_W1 = MAN_W + 1;
  logic [IN_W-1:0]  w_rem;
  logic [IN_W-1:0]  w_half;
  logic             w_rnd_up;
  logic [MAN_W:0]   w_man_sum;
`endif

  // A stage moves forward when it is empty or the stage after it moves; bubbles collapse
  assign w_s2_adv  = ~r_s2_valid | out_ready;
  assign w_s1_adv  = ~r_s1_valid | w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_valid;
  assign out_exp   = r_exp;
  assign out_man   = r_man;
  assign out_sat   = r_sat;

  // Leading-one search: the highest set bit wins
  always_comb begin
    w_p = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (in_data[i]) w_p = P_W'(i);
    end
    w_small = ~|in_data[IN_W-1:MAN_W];
  end

  // Stage 1 register: accept a new word whenever stage 1 can advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_p     <= '0;
      r_s1_small <= 1'b0;
    end else begin
      if (w_s1_adv) r_s1_valid <= in_valid;
      if (w_s1_adv && in_valid) begin
        r_s1_x     <= in_data;
        r_s1_p     <= w_p;
        r_s1_small <= w_small;
      end
    end
  end

  // Mantissa extraction, exponent, optional rounding and saturation
  always_comb begin
    // Shift amount only meaningful for non-small words; small words bypass this path
    w_shamt = r_s1_p - P_W'(MAN_W);
    w_man_t = MAN_W'(r_s1_x >> w_shamt);
    w_exp_t = 32'(r_s1_p) + 32'd1 - 32'(MAN_W);
`ifdef INT2FLOAT_RNE_EN
    w_rem     = r_s1_x & ((IN_W'(1) << w_shamt) - IN_W'(1));
    w_half    = (w_shamt == '0) ? '0 : (IN_W'(1) << (w_shamt - P_W'(1)));
    // No discarded bits when the shift is zero, so nothing to round
    w_rnd_up  = (w_shamt != '0) &&
                ((w_rem > w_half) || ((w_rem == w_half) && w_man_t[0]));
    w_man_sum = {1'b0, w_man_t} + MAN_W1'(w_rnd_up);
    w_man_r   = w_man_sum[MAN_W-1:0];
    // Carry out of the mantissa bumps the exponent; may then saturate
    w_exp_r   = w_exp_t + 32'(w_man_sum[MAN_W]);
`else
    w_man_r = w_man_t;
    w_exp_r = w_exp_t;
`endif
    w_exp_n = '0;
    w_man_n = '0;
    w_sat_n = 1'b0;
    if (r_s1_small) begin
      w_man_n = r_s1_x[MAN_W-1:0];
    end else if (w_exp_r > EXP_MAX) begin
      w_exp_n = '1;
      w_man_n = '1;
      w_sat_n = 1'b1;
    end else begin
      w_exp_n = w_exp_r[EXP_W-1:0];
      w_man_n = w_man_r;
    end
  end

  // Stage 2 register: outputs only change when a stage-1 word moves in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_exp      <= '0;
      r_man      <= '0;
      r_sat      <= 1'b0;
    end else begin
      if (w_s2_adv) r_s2_valid <= r_s1_valid;
      if (w_s2_adv && r_s1_valid) begin
        r_exp <= w_exp_n;
        r_man <= w_man_n;
        r_sat <= w_sat_n;
      end
    end
  end

endmodule
